// File: rtl/seq_1011_gen.sv
// Burst generator for the serial pattern 1011, with overlapping/non-overlapping framing.
// Optional inter-frame gap cycle compiled only under macro SEQ_1011_GEN_GAP_EN.
module seq_1011_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ovl,
    input  logic [3:0] count,
    output logic       x,
    output logic       valid,
    output logic       mark,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S0   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
`ifdef SEQ_1011_GEN_GAP_EN
        GAP  = 3'd5,
`endif
        FIN  = 3'd6
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] frames_reg, frames_next;
    logic       ovl_reg, ovl_next;
    logic       x_reg, valid_reg, mark_reg, done_reg;
    logic       x_next, valid_next, mark_next, done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            frames_reg <= 4'd0;
            ovl_reg    <= 1'b0;
            x_reg      <= 1'b0;
            valid_reg  <= 1'b0;
            mark_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            frames_reg <= frames_next;
            ovl_reg    <= ovl_next;
            x_reg      <= x_next;
            valid_reg  <= valid_next;
            mark_reg   <= mark_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        frames_next = frames_reg;
        ovl_next    = ovl_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    ovl_next    = ovl;
                    frames_next = count;
                    state_next  = (count == 4'd0) ? FIN : S1;
                end
            end
            S1: state_next = S0;
            S0: state_next = S2;
            S2: state_next = S3;
            S3: begin
                frames_next = frames_reg - 4'd1;
                if (frames_reg <= 4'd1) begin
                    state_next = FIN;
                end else if (ovl_reg) begin
                    // Trailing 1 doubles as the leading 1 of the next frame.
                    state_next = S0;
                end else begin
`ifdef SEQ_1011_GEN_GAP_EN
                    state_next = GAP;
`else
                    state_next = S1;
`endif
                end
            end
`ifdef SEQ_1011_GEN_GAP_EN
            GAP: state_next = S1;
`endif
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        x_next     = 1'b0;
        valid_next = 1'b0;
        mark_next  = 1'b0;
        done_next  = 1'b0;
        case (state_next)
            S1: begin
                x_next     = 1'b1;
                valid_next = 1'b1;
            end
            S0: valid_next = 1'b1;
            S2: begin
                x_next     = 1'b1;
                valid_next = 1'b1;
            end
            S3: begin
                x_next     = 1'b1;
                valid_next = 1'b1;
                mark_next  = 1'b1;
            end
`ifdef SEQ_1011_GEN_GAP_EN
            GAP: valid_next = 1'b1;
`endif
            FIN:     done_next = 1'b1;
            default: ;
        endcase
    end

    assign x     = x_reg;
    assign valid = valid_reg;
    assign mark  = mark_reg;
    assign busy  = valid_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_seq_1011_gen.sv
// Table-driven bench for seq_1011_gen plus long-burst sequences.
// Expected codes per cycle: '1' x=1 frame bit, '0' x=0 frame bit, 'M' final 1, 'D' done, '.' idle.
module tb_seq_1011_gen;

    logic       clk = 1'b0;
    logic       rst, start, ovl;
    logic [3:0] count;
    logic       x, valid, mark, busy, done;

    int checks = 0;
    int failures = 0;

    seq_1011_gen dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .ovl  (ovl),
        .count(count),
        .x    (x),
        .valid(valid),
        .mark (mark),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       ovl;
        logic [3:0] count;
        logic [4:0] exp;   // {x, valid, mark, busy, done}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] code(input byte c);
        case (c)
            "1":     return 5'b11010;
            "0":     return 5'b01010;
            "G":     return 5'b01010;
            "M":     return 5'b11110;
            "D":     return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    // First row carries the given inputs; remaining rows drive all inputs low.
    task automatic add_seq(input logic r, input logic s, input logic o,
                           input logic [3:0] c, input string pat);
        vec_t v;
        for (int i = 0; i < pat.len(); i++) begin
            v.rst   = (i == 0) ? r : 1'b0;
            v.start = (i == 0) ? s : 1'b0;
            v.ovl   = (i == 0) ? o : 1'b0;
            v.count = (i == 0) ? c : 4'd0;
            v.exp   = code(pat[i]);
            vecs.push_back(v);
        end
    endtask

    task automatic long_burst(input logic o, input int exp_bits, input string name);
        int  nvalid;
        int  nmark;
        logic bad;
        logic got_done;
        nvalid = 0; nmark = 0; bad = 1'b0; got_done = 1'b0;
        rst = 1'b0; start = 1'b1; ovl = o; count = 4'd15;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (valid) nvalid++;
            if (mark) nmark++;
            if (busy !== valid || (!valid && x !== 1'b0)) bad = 1'b1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL %s_done: no done pulse within 200 cycles", name);
        end
        checks++;
        if (nvalid != exp_bits) begin
            failures++;
            $display("FAIL %s_bits: got %0d valid bits, expected %0d", name, nvalid, exp_bits);
        end
        checks++;
        if (nmark != 15) begin
            failures++;
            $display("FAIL %s_marks: got %0d marks, expected 15", name, nmark);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_consistency: busy/valid/x disagreed on some cycle, expected busy=valid and x=0 when idle", name);
        end
        @(posedge clk); #1;
        checks++;
        if ({x, valid, mark, busy, done} !== 5'b00000) begin
            failures++;
            $display("FAIL %s_after: got %b, expected 00000", name, {x, valid, mark, busy, done});
        end
        $display("burst %s: bits=%0d marks=%0d done=%0d", name, nvalid, nmark, got_done);
    endtask

    initial begin
        logic [4:0] got;
        rst = 1'b1; start = 1'b0; ovl = 1'b0; count = 4'd0;

        add_seq(1, 0, 0, 0, "..");                 // reset state
        add_seq(0, 0, 0, 0, "..");
        add_seq(0, 1, 0, 1, "101MD..");            // count=1, ovl=0
        add_seq(0, 1, 1, 3, "101M01M01MD.");       // count=3, ovl=1
`ifdef SEQ_1011_GEN_GAP_EN
        add_seq(0, 1, 0, 2, "101MG101MD.");        // count=2, ovl=0, gapped
`else
        add_seq(0, 1, 0, 2, "101M101MD.");         // count=2, ovl=0, back-to-back
`endif
        add_seq(0, 1, 0, 0, "D..");                // count=0
        add_seq(0, 1, 0, 1, "1");                  // start re-pulsed mid-burst
        add_seq(0, 1, 1, 3, "01M");
        add_seq(0, 0, 0, 0, "D");
        add_seq(0, 1, 0, 2, "..");                 // start during FIN ignored
        add_seq(0, 1, 0, 1, "1");                  // ovl/count wiggle after latch
        add_seq(0, 0, 1, 9, "01MD.");
        add_seq(0, 1, 0, 2, "101");                // reset on cycle 3 of burst
        add_seq(1, 0, 0, 0, ".....");
        add_seq(1, 1, 0, 1, "..");                 // rst beats start
        add_seq(0, 1, 1, 1, "101MD.");             // fresh start accepted

        foreach (vecs[i]) begin
            rst   = vecs[i].rst;
            start = vecs[i].start;
            ovl   = vecs[i].ovl;
            count = vecs[i].count;
            @(posedge clk); #1;
            got = {x, valid, mark, busy, done};
            checks++;
            if (got !== vecs[i].exp) begin
                failures++;
                $display("FAIL vec%0d: got {x,valid,mark,busy,done}=%b, expected %b",
                         i, got, vecs[i].exp);
            end else begin
                $display("vec%0d rst=%0b start=%0b ovl=%0b count=%0d -> %b",
                         i, vecs[i].rst, vecs[i].start, vecs[i].ovl, vecs[i].count, got);
            end
        end

        long_burst(1'b1, 46, "ovl15");
`ifdef SEQ_1011_GEN_GAP_EN
        long_burst(1'b0, 74, "nonovl15");
`else
        long_burst(1'b0, 60, "nonovl15");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_1011_gen.md
SEQ_1011_GEN -- requirements
Module: seq_1011_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a burst; sampled only in IDLE.
REQ-004 SHALL have port ovl, input, 1 bit: 1 = overlapping frames, 0 = non-overlapping; latched on accepted start.
REQ-005 SHALL have port count, input, 4 bits: number of 1011 frames (0-15); latched on accepted start.
REQ-006 SHALL have port x, output, 1 bit: serial stimulus bit; registered; 0 whenever valid=0.
REQ-007 SHALL have port valid, output, 1 bit: x carries a stream bit this cycle.
REQ-008 SHALL have port mark, output, 1 bit: high on the cycle x carries the final 1 of a frame (golden detector z).
REQ-009 SHALL have port busy, output, 1 bit: burst in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at burst end.

Function
REQ-011 SHALL implement states IDLE, S1 (x=1), S0 (x=0), S2 (x=1), S3 (x=1, mark=1), GAP (x=0, macro only), FIN (done=1).
REQ-012 SHALL, in IDLE with start=1 and count>0, go to S1 and load the frame counter with count; the first bit appears one cycle after start is sampled.
REQ-013 SHALL, in IDLE with start=1 and count=0, go to FIN; done pulses one cycle after start; valid, busy and mark stay 0.
REQ-014 SHALL sequence S1->S0->S2->S3; in S3 the frame counter decrements.
REQ-015 SHALL, from S3 with frames remaining: go to S0 if ovl=1 (last 1 shared, giving 1011011...); go to S1 if ovl=0, or to GAP when GAP_EN is defined.
REQ-016 SHALL, from S3 on the last frame, go to FIN; FIN always returns to IDLE after one cycle.
REQ-017 SHALL hold valid=1 and busy=1 in S1, S0, S2, S3 and GAP, and 0 in IDLE and FIN.
REQ-018 SHALL emit exactly 4N bits for ovl=0 without gaps, 5N-1 bits with gaps, and 3N+1 bits for ovl=1.
REQ-019 SHALL ignore start while not in IDLE, including in the FIN cycle.
REQ-020 SHALL ignore changes on ovl and count after they are latched.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, force IDLE, clear the frame counter, and drive x=valid=mark=busy=done=0 from the next cycle.
REQ-022 SHALL give rst priority over start on the same edge; a burst aborted by reset produces no done pulse.

Configuration
REQ-023 SHALL compile GAP_EN support only under macro SEQ_1011_GEN_GAP_EN.
REQ-024 SHALL, when the macro is defined and ovl=0, insert one GAP cycle (valid=1, x=0, mark=0) between consecutive frames, never after the last frame.
REQ-025 SHALL never insert GAP when ovl=1; when the macro is undefined the GAP state SHALL not exist and non-overlapping frames run back-to-back.

Verification
REQ-026 SHALL cover: count=1, ovl=0 -> x=1,0,1,1 on cycles 1-4 after start; mark on cycle 4; done on cycle 5; busy on cycles 1-4.
REQ-027 SHALL cover: count=3, ovl=1 -> x=1011011011 over 10 cycles; mark on cycles 4, 7, 10; done on cycle 11.
REQ-028 SHALL cover: count=2, ovl=0 -> without macro x=10111011 with mark on cycles 4 and 8; with macro x=101101011 with mark on cycles 4 and 9.
REQ-029 SHALL cover: count=0 with start -> done on cycle 1 only; valid and busy never asserted.
REQ-030 SHALL cover: start pulsed during a burst with a new count -> burst unchanged.
REQ-031 SHALL cover: rst asserted on cycle 3 of a count=2 burst -> all outputs 0 from the next cycle, no done pulse; a new start is then accepted normally.
